// File: rtl/periph_pkg.sv
// periph_pkg: shared address map and TCON bit positions for memory-mapped peripherals.
package periph_pkg;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;
  // Offsets are word indices, compared against addr[3:2].
  localparam logic [1:0] OFF_TH = 2'd0;
  localparam logic [1:0] OFF_TL = 2'd1;
  localparam logic [1:0] OFF_TCON = 2'd2;
  localparam logic [1:0] OFF_PSC = 2'd3;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
endpackage

// File: rtl/timer_irq_if.sv
// timer_irq_if: data-memory bus slice seen by the timer, plus its interrupt line.
interface timer_irq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic rd;
  logic wr;
  logic irq;
  modport master (output addr, wdata, rd, wr, input rdata, irq);
  modport slave (input addr, wdata, rd, wr, output rdata, irq);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the count tick by PSC+1 while enabled.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] psc,
  output logic        tick
);
  logic [15:0] pcnt_q, pcnt_d;
  assign tick = en & (pcnt_q == psc);
  assign pcnt_d = (clr | ~en | tick) ? '0 : pcnt_q + 16'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped reload timer driving the CPU level IRQ.
// Define TIMER_PRESCALE_EN to add the PSC register at +0xC and the tick prescaler.
module timer_irq
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input logic       clk,
  input logic       reset,
  timer_irq_if.slave bus
);
  logic [31:0] th_q, th_d, tl_q, tl_d, psc_rd;
  logic en_q, en_d, ie_q, ie_d, is_q, is_d;
  logic hit, we_th, we_tl, we_tcon, tick, ovf, unused_addr;
  logic [1:0] sel;
  assign unused_addr = ^bus.addr[1:0];
  assign hit = bus.addr[31:4] == BASE_ADDR[31:4];
  assign sel = bus.addr[3:2];
  assign we_th = bus.wr & hit & (sel == OFF_TH);
  assign we_tl = bus.wr & hit & (sel == OFF_TL);
  assign we_tcon = bus.wr & hit & (sel == OFF_TCON);
`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc_q;
  logic we_psc;
  assign we_psc = bus.wr & hit & (sel == OFF_PSC);
  assign psc_rd = {16'b0, psc_q};
  always_ff @(posedge clk or posedge reset)
    if (reset) psc_q <= '0;
    else if (we_psc) psc_q <= bus.wdata[15:0];
  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .clr   (we_psc),
    .psc   (psc_q),
    .tick  (tick)
  );
`else
  assign psc_rd = '0;
  assign tick = en_q;
`endif
  assign ovf = tick & (tl_q == '1);
  // Software writes to TL beat counting; the hardware IS set beats a software clear.
  always_comb begin
    th_d = we_th ? bus.wdata : th_q;
    tl_d = we_tl ? bus.wdata : ovf ? th_q : tick ? tl_q + 32'd1 : tl_q;
    en_d = we_tcon ? bus.wdata[TCON_EN] : en_q;
    ie_d = we_tcon ? bus.wdata[TCON_IE] : ie_q;
    is_d = (ovf & ie_q) | (we_tcon ? bus.wdata[TCON_IS] : is_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      th_q <= '0;
      tl_q <= '0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      is_q <= 1'b0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
      en_q <= en_d;
      ie_q <= ie_d;
      is_q <= is_d;
    end
  assign bus.rdata = !(bus.rd && hit) ? '0 :
                     sel == OFF_TH   ? th_q :
                     sel == OFF_TL   ? tl_q :
                     sel == OFF_TCON ? {29'b0, is_q, ie_q, en_q} : psc_rd;
  assign bus.irq = ie_q & is_q;
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed register-level checks of timer_irq, inputs driven on falling edges.
module tb_timer_irq;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  timer_irq_if bus ();
  timer_irq #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus.addr = BASE + 32'(off);
    bus.rd = 1'b1;
    #1;
    check(tag, bus.rdata, exp);
    bus.rd = 1'b0;
  endtask
  task automatic irq_chk(input string tag, input logic exp);
    check(tag, {31'b0, bus.irq}, {31'b0, exp});
  endtask
  task automatic wr_reg(input logic [7:0] off, input logic [31:0] data);
    bus.addr = BASE + 32'(off);
    bus.wdata = data;
    bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask
  initial begin
    bus.addr = BASE;
    bus.wdata = '0;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    repeat (2) @(negedge clk);
    rd_chk("rst_th", 8'h0, 32'h0);
    rd_chk("rst_tl", 8'h4, 32'h0);
    rd_chk("rst_tcon", 8'h8, 32'h0);
    irq_chk("rst_irq", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    wr_reg(8'h0, 32'hFFFF_FFF0);
    wr_reg(8'h4, 32'hFFFF_FFFE);
    wr_reg(8'h8, 32'h3);
    irq_chk("irq_w0", 1'b0);
    bus.addr = BASE + 32'h4;
    #1 check("rd0_zero", bus.rdata, 32'h0);
    @(negedge clk);
    irq_chk("irq_w1", 1'b0);
    rd_chk("tl_max", 8'h4, 32'hFFFF_FFFF);
    @(negedge clk);
    irq_chk("irq_w2", 1'b1);
    rd_chk("tl_reload", 8'h4, 32'hFFFF_FFF0);
    rd_chk("tcon_is", 8'h8, 32'h7);
    wr_reg(8'h8, 32'h3);
    irq_chk("irq_clr", 1'b0);
    repeat (14) @(negedge clk);
    irq_chk("irq_pre2", 1'b0);
    rd_chk("tl_max2", 8'h4, 32'hFFFF_FFFF);
    @(negedge clk);
    irq_chk("irq_period", 1'b1);
    wr_reg(8'h8, 32'h1);
    irq_chk("irq_ie0", 1'b0);
    repeat (15) @(negedge clk);
    rd_chk("tl_reload_ie0", 8'h4, 32'hFFFF_FFF0);
    rd_chk("tcon_ie0", 8'h8, 32'h1);
    irq_chk("irq_ie0_ovf", 1'b0);
    wr_reg(8'h8, 32'h3);
    repeat (14) @(negedge clk);
    rd_chk("tl_max3", 8'h4, 32'hFFFF_FFFF);
    wr_reg(8'h8, 32'h3);
    rd_chk("is_race", 8'h8, 32'h7);
    irq_chk("irq_race", 1'b1);
    rd_chk("tl_race", 8'h4, 32'hFFFF_FFF0);
    repeat (15) @(negedge clk);
    wr_reg(8'h4, 32'h5);
    rd_chk("tl_wr_ovf", 8'h4, 32'h5);
    bus.addr = BASE;
    bus.wdata = 32'h1234_5678;
    bus.rd = 1'b1;
    bus.wr = 1'b1;
    #1 check("rdwr_old", bus.rdata, 32'hFFFF_FFF0);
    @(negedge clk);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    rd_chk("rdwr_new", 8'h0, 32'h1234_5678);
    wr_reg(8'h8, 32'hFFFF_FFF8);
    rd_chk("tcon_mask", 8'h8, 32'h0);
    bus.addr = BASE + 32'h10;
    bus.rd = 1'b1;
    #1 check("miss", bus.rdata, 32'h0);
    bus.rd = 1'b0;
`ifndef TIMER_PRESCALE_EN
    wr_reg(8'hC, 32'hDEAD_BEEF);
    rd_chk("unmapped_c", 8'hC, 32'h0);
`else
    wr_reg(8'hC, 32'hDEAD_0003);
    rd_chk("psc_rd", 8'hC, 32'h0000_0003);
    wr_reg(8'h4, 32'h0);
    wr_reg(8'h8, 32'h1);
    repeat (3) @(negedge clk);
    rd_chk("psc_tl0", 8'h4, 32'h0);
    @(negedge clk);
    rd_chk("psc_tl1", 8'h4, 32'h1);
    repeat (4) @(negedge clk);
    rd_chk("psc_tl2", 8'h4, 32'h2);
`endif
    wr_reg(8'h8, 32'h7);
    irq_chk("irq_sw_set", 1'b1);
    #2 reset = 1'b1;
    #1 irq_chk("irq_async_rst", 1'b0);
    rd_chk("rst2_th", 8'h0, 32'h0);
    rd_chk("rst2_tl", 8'h4, 32'h0);
    rd_chk("rst2_tcon", 8'h8, 32'h0);
    rd_chk("rst2_c", 8'hC, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("no_count", 8'h4, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
